// File: rtl/my_reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
package my_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  // Largest of three values; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/my_reset_sequencer_sync2.sv
// Generic two-flop synchroniser, async active-high reset to 0.
module my_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Two back-to-back flops to settle a metastable input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/my_reset_sequencer.sv
// Board reset sequencer: lock filter, hold, staggered domain release,
// cause tracking and a free-running divided system clock.
module my_reset_sequencer
  import my_rst_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYCLES = 128,
  parameter int STAGGER     = 16,
  parameter int LOCK_FILTER = 4,
  parameter int CLK_DIV     = 2
) (
  input  logic             pll_clk,
  input  logic             i_brd_rst,
  input  logic             i_pll_locked,
  input  logic             i_sw_rst_req,
  output logic [N_DOM-1:0] o_rst,
  output logic             o_sys_clk,
  output logic             o_clk_en,
  output logic             o_system_ready,
  output logic [1:0]       o_rst_cause
);

  localparam int CNT_W = $clog2(max3(LOCK_FILTER, HOLD_CYCLES, STAGGER) + 1);
  localparam int IDX_W = $clog2(N_DOM + 1);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2 - 1);

  logic             w_lk_s;
  rst_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_DOM-1:0] r_rst, w_rst_nxt;
  logic             r_rdy, w_rdy_nxt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic [DIV_W-1:0] r_div;
  logic             r_sys_clk;

  my_sync2 u_lock_sync (
    .i_clk (pll_clk),
    .i_rst (i_brd_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lk_s)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge pll_clk or posedge i_brd_rst) begin
    if (i_brd_rst) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_rdy   <= 1'b0;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst   <= w_rst_nxt;
      r_rdy   <= w_rdy_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Next-state: filter lock, hold, release one domain per stagger period;
  // lock loss outranks a software request and both restart the sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_rdy_nxt   = 1'b0;
    w_cause_nxt = r_cause;
    case (r_state)
      WAIT_LOCK: begin
        if (!w_lk_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt    = '0;
          w_rst_nxt[0] = 1'b0;
          w_idx_nxt    = IDX_W'(1);
          w_state_nxt  = (N_DOM == 1) ? RUN : RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (r_cnt == STG_LAST) begin
          w_cnt_nxt = '0;
          for (int k = 0; k < N_DOM; k++) begin
            if (IDX_W'(k) == r_idx) w_rst_nxt[k] = 1'b0;
          end
          w_idx_nxt = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RUN: w_rdy_nxt = 1'b1;
      default: w_state_nxt = WAIT_LOCK;
    endcase
    if ((r_state != WAIT_LOCK) && !w_lk_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_rdy_nxt   = 1'b0;
      w_cause_nxt = CAUSE_LOCK;
    end else if ((r_state == RUN) && i_sw_rst_req) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_rdy_nxt   = 1'b0;
      w_cause_nxt = CAUSE_SW;
    end
  end

  // Free-running divider: high for the first half of each period after a wrap,
  // so the enable on the last count lands just before every rising edge.
  always_ff @(posedge pll_clk or posedge i_brd_rst) begin
    if (i_brd_rst) begin
      r_div     <= '0;
      r_sys_clk <= 1'b0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      if (r_div == DIV_LAST)      r_sys_clk <= 1'b1;
      else if (r_div == DIV_HALF) r_sys_clk <= 1'b0;
    end
  end

  assign o_rst          = r_rst;
  assign o_system_ready = r_rdy;
  assign o_rst_cause    = r_cause;
  assign o_sys_clk      = r_sys_clk;
  assign o_clk_en       = (r_div == DIV_LAST);

endmodule

// File: tb/tb_my_reset_sequencer.sv
// Bench: directed vector table, randomized run against a timeline model,
// and a divide-by-4 instance for the divider corner cases.
module tb_my_reset_sequencer;
  localparam int N = 3, LF = 4, HC = 128, ST = 16;

  logic pll_clk = 1'b0, i_brd_rst = 1'b1, i_pll_locked = 1'b1, i_sw_rst_req = 1'b0;
  logic [N-1:0] rst_a, rst_b;
  logic clk_a, clk_b, en_a, en_b, rdy_a, rdy_b;
  logic [1:0] cause_a, cause_b;
  int nerr = 0, nchk = 0;

  always #5 pll_clk = ~pll_clk;

  my_reset_sequencer u_dut (
    .pll_clk(pll_clk), .i_brd_rst(i_brd_rst), .i_pll_locked(i_pll_locked),
    .i_sw_rst_req(i_sw_rst_req), .o_rst(rst_a), .o_sys_clk(clk_a), .o_clk_en(en_a),
    .o_system_ready(rdy_a), .o_rst_cause(cause_a));

  my_reset_sequencer #(.CLK_DIV(4)) u_div4 (
    .pll_clk(pll_clk), .i_brd_rst(i_brd_rst), .i_pll_locked(i_pll_locked),
    .i_sw_rst_req(i_sw_rst_req), .o_rst(rst_b), .o_sys_clk(clk_b), .o_clk_en(en_b),
    .o_system_ready(rdy_b), .o_rst_cause(cause_b));

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  // Timeline model: t0 is the edge lock became visible after sync; domain k
  // is free from t0+LF+HC+k*ST onward as long as the attempt is not aborted.
  int e = 0, t0 = 0;
  bit armed = 1'b0;
  logic p1 = 1'b0, p2 = 1'b0;
  logic [1:0] m_cause = 2'd0;
  logic [N-1:0] x_rst;
  logic x_rdy;

  function automatic logic [1:0] divexp(input int ee, input int d);
    divexp = {(ee >= d) && ((ee % d) < d / 2), (ee % d) == d - 1};
  endfunction

  always @(posedge pll_clk) begin : model
    int r_end;
    logic l;
    if (i_brd_rst) begin
      e = 0; p1 = 1'b0; p2 = 1'b0; armed = 1'b0; m_cause = 2'd0;
    end else begin
      e++;
      l = p2; p2 = p1; p1 = i_pll_locked;
      r_end = t0 + LF + HC + (N - 1) * ST;
      if (armed && !l) begin
        if (e > t0 + LF) m_cause = 2'd1;
        armed = 1'b0;
      end else if (armed && i_sw_rst_req && e > r_end) begin
        m_cause = 2'd2;
        t0 = e;
      end else if (!armed && l) begin
        armed = 1'b1;
        t0 = e - 1;
      end
    end
    for (int k = 0; k < N; k++) x_rst[k] = !(armed && e >= t0 + LF + HC + k * ST);
    x_rdy = armed && (e >= t0 + LF + HC + (N - 1) * ST + 1);
    #1;
    check("cycle_div2", {rst_a, rdy_a, cause_a, clk_a, en_a}, {x_rst, x_rdy, m_cause, divexp(e, 2)});
    check("cycle_div4", {rst_b, rdy_b, cause_b, clk_b, en_b}, {x_rst, x_rdy, m_cause, divexp(e, 4)});
  end

  typedef struct {
    int         n;
    logic       lock;
    logic       sw;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[30];

  initial begin
    // Cycle counts are edges since the previous check; lock held, sw for one edge.
    tbl[0]  = '{133, 1, 0, 3'b111, 0, 0};
    tbl[1]  = '{1,   1, 0, 3'b110, 0, 0};
    tbl[2]  = '{15,  1, 0, 3'b110, 0, 0};
    tbl[3]  = '{1,   1, 0, 3'b100, 0, 0};
    tbl[4]  = '{15,  1, 0, 3'b100, 0, 0};
    tbl[5]  = '{1,   1, 0, 3'b000, 0, 0};
    tbl[6]  = '{1,   1, 0, 3'b000, 1, 0};
    tbl[7]  = '{2,   0, 0, 3'b000, 1, 0};
    tbl[8]  = '{1,   0, 0, 3'b111, 0, 1};
    tbl[9]  = '{133, 1, 0, 3'b111, 0, 1};
    tbl[10] = '{1,   1, 0, 3'b110, 0, 1};
    tbl[11] = '{33,  1, 0, 3'b000, 1, 1};
    tbl[12] = '{1,   1, 1, 3'b111, 0, 2};
    tbl[13] = '{131, 1, 0, 3'b111, 0, 2};
    tbl[14] = '{1,   1, 0, 3'b110, 0, 2};
    tbl[15] = '{3,   0, 0, 3'b111, 0, 1};
    tbl[16] = '{50,  1, 0, 3'b111, 0, 1};
    tbl[17] = '{1,   1, 1, 3'b111, 0, 1};
    tbl[18] = '{82,  1, 0, 3'b111, 0, 1};
    tbl[19] = '{1,   1, 0, 3'b110, 0, 1};
    tbl[20] = '{33,  1, 0, 3'b000, 1, 1};
    tbl[21] = '{1,   1, 1, 3'b111, 0, 2};
    tbl[22] = '{164, 1, 0, 3'b000, 0, 2};
    tbl[23] = '{1,   1, 0, 3'b000, 1, 2};
    tbl[24] = '{2,   0, 0, 3'b000, 1, 2};
    tbl[25] = '{1,   0, 1, 3'b111, 0, 1};
    tbl[26] = '{3,   1, 0, 3'b111, 0, 1};
    tbl[27] = '{1,   0, 0, 3'b111, 0, 1};
    tbl[28] = '{133, 1, 0, 3'b111, 0, 1};
    tbl[29] = '{1,   1, 0, 3'b110, 0, 1};

    repeat (3) @(negedge pll_clk);
    check("reset_div2", {rst_a, rdy_a, cause_a, clk_a, en_a}, 8'b111_0_00_0_0);
    check("reset_div4", {rst_b, rdy_b, cause_b, clk_b, en_b}, 8'b111_0_00_0_0);
    i_brd_rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      i_pll_locked = tbl[i].lock;
      i_sw_rst_req = tbl[i].sw;
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge pll_clk);
        i_sw_rst_req = 1'b0;
      end
      check($sformatf("vec%0d", i), {2'b00, rst_a, rdy_a, cause_a},
            {2'b00, tbl[i].rst, tbl[i].rdy, tbl[i].cause});
    end

    // Randomized traffic: mostly locked, occasional drops, sw pulses, board resets.
    for (int c = 0; c < 6000; c++) begin
      @(negedge pll_clk);
      i_sw_rst_req = ($urandom_range(0, 29) == 0);
      if (i_pll_locked ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
        i_pll_locked = ~i_pll_locked;
      if (i_brd_rst) i_brd_rst = 1'b0;
      else if ($urandom_range(0, 1999) == 0) i_brd_rst = 1'b1;
    end

    // Board reset in the high half of a divide-by-4 period forces the clock low at once.
    @(negedge pll_clk);
    i_brd_rst = 1'b0; i_sw_rst_req = 1'b0; i_pll_locked = 1'b1;
    for (int j = 0; j < 10 && !(e >= 4 && (e % 4) == 0); j++) @(negedge pll_clk);
    check("div4_high_before_rst", {7'd0, clk_b}, 8'd1);
    i_brd_rst = 1'b1;
    #1;
    check("div4_async_rst", {rst_b, rdy_b, cause_b, clk_b, en_b}, 8'b111_0_00_0_0);
    repeat (2) @(negedge pll_clk);
    i_brd_rst = 1'b0;
    repeat (4) @(negedge pll_clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/my_reset_sequencer.md
Name: my_reset_sequencer

Overview:
Parametrised successor to the board clock/reset block. It filters PLL lock and holds all reset domains for a programmable time. It then releases N reset domains in a fixed staggered order, lowest index first. It also generates a divided system clock plus a matching clock-enable, re-sequences on PLL lock loss or software request, and records the cause of the last reset. It sits at top level between the board PLL and every reset consumer (core, memory controller, peripherals).

Parameters:
N_DOM, 3, number of reset domains (1..8); released index 0 first.
HOLD_CYCLES, 128, pll_clk cycles all domains stay in reset after lock is qualified (>=1).
STAGGER, 16, pll_clk cycles between consecutive domain releases (>=1).
LOCK_FILTER, 4, consecutive synchronised-lock-high cycles required to qualify lock (>=1).
CLK_DIV, 2, pll_clk-to-o_sys_clk ratio; even, >=2.

Ports:
pll_clk  in  1  system PLL output clock; all logic is on its rising edge.
i_brd_rst  in  1  board reset; asynchronous, active-high.
i_pll_locked  in  1  raw PLL lock; asynchronous, 2-FF synchronised internally.
i_sw_rst_req  in  1  single-cycle software reset request, pll_clk domain.
o_rst  out  N_DOM  per-domain reset, active-high, registered.
o_sys_clk  out  1  divided clock, 50% duty, registered.
o_clk_en  out  1  one-cycle pulse per o_sys_clk period.
o_system_ready  out  1  high once all domains are released.
o_rst_cause  out  2  last reset cause: 0=POR/board, 1=lock loss, 2=software.

Behaviour:
- Async reset (i_brd_rst=1): o_rst all 1s, o_sys_clk=0, o_clk_en=0, o_system_ready=0, o_rst_cause=0, sync FFs, counters and div counter 0, state WAIT_LOCK.
- Lock sync: lk_s = 2-FF synchronised i_pll_locked. All lock decisions use lk_s.
- FSM states: WAIT_LOCK, HOLD, RELEASE, RUN.
- WAIT_LOCK: the filter counter increments while lk_s=1 and clears when lk_s=0. At LOCK_FILTER consecutive highs, go to HOLD and clear the counter.
- HOLD: count HOLD_CYCLES. On the final count, o_rst[0] goes 0 at the next edge and the FSM goes to RELEASE.
- RELEASE: every STAGGER cycles, deassert the next domain index. After o_rst[N_DOM-1] deasserts, go to RUN; o_system_ready rises one cycle later.
- Timing: with T0 = first edge with lk_s=1 and lk_s stable thereafter, o_rst[k] falls at edge T0+LOCK_FILTER+HOLD_CYCLES+k*STAGGER.
- Release order: o_rst deasserts only in increasing index order and is never partially re-asserted.
- Lock loss (lk_s=0) in HOLD, RELEASE or RUN: at the next edge, all o_rst=1, o_system_ready=0, o_rst_cause=1, FSM to WAIT_LOCK.
- Software request in RUN: at the next edge, all o_rst=1, o_system_ready=0, o_rst_cause=2, FSM to WAIT_LOCK, so the full sequence repeats.
- Software request outside RUN is ignored.
- Lock loss and software request in the same cycle: lock loss wins, cause=1.
- o_rst_cause holds its value until the next cause event; it is only cleared by i_brd_rst.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. o_sys_clk toggles when div_cnt wraps to 0 and when div_cnt reaches CLK_DIV/2. o_clk_en=1 exactly when div_cnt==CLK_DIV-1, i.e. the cycle before the o_sys_clk rising edge.
- The divider is free-running from i_brd_rst release and is unaffected by lock loss or software reset.
- Counter widths use $clog2(max+1). No counter may overflow or wrap except div_cnt.

Decomposition:
- Package my_rst_pkg holds the FSM state enum (WAIT_LOCK, HOLD, RELEASE, RUN) and the cause constants CAUSE_POR=2'd0, CAUSE_LOCK=2'd1, CAUSE_SW=2'd2.
- One sub-module, my_sync2: a generic 2-FF synchroniser with async active-high reset to 0, used for i_pll_locked.
- The divider stays inline.

Test Plan:
- Defaults; release i_brd_rst with i_pll_locked=1 -> o_rst[0] falls at T0+132, o_rst[1] at T0+148, o_rst[2] at T0+164; o_system_ready=1 at T0+165; o_rst_cause=0.
- Lock glitch: i_pll_locked high 3 cycles, low 1, then high -> the filter restarts and the o_rst[0] release is delayed by the glitch length plus 3 cycles; o_rst stays all 1s during the glitch.
- Lock drop in RUN, then restore -> all o_rst=1 and ready=0 two sync cycles plus one edge after the drop; o_rst_cause=1; the full sequence re-runs after restore.
- Lock drop mid-RELEASE (after o_rst[0] has fallen) -> o_rst[0] re-asserts; o_rst_cause=1; no domain releases out of order on retry.
- i_sw_rst_req pulse in RUN -> all o_rst=1 next edge and o_rst_cause=2. A pulse during HOLD is ignored, and a pulse coincident with lock loss gives cause=1.
- CLK_DIV=4: o_sys_clk has period 4 pll_clk and 50% duty; o_clk_en is one cycle high per 4, preceding each rise; asserting i_brd_rst mid-period forces o_sys_clk=0.
